// File: rtl/control_ventilacion_alarma.sv
// Ventilation/alarm supervisory controller: banded temperature classification with
// hysteresis, debounce, alarm hold and acknowledge. Define ALARMA_LATCH_EN to latch ALARM.
module control_ventilacion_alarma #(
    parameter int W       = 5,
    parameter int T_VENT  = 20,
    parameter int T_ALARM = 26,
    parameter int HYST    = 2,
    parameter int DEB_CYC = 4,
    parameter int HOLD    = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] Temperatura,
    input  logic         Muestra,
    input  logic         Reconocer,
    output logic         Ventilacion,
    output logic         Alarma,
    output logic [1:0]   Estado
);

    typedef enum logic [1:0] {
        S_NORMAL = 2'b00,
        S_VENT   = 2'b01,
        S_ALARM  = 2'b10,
        S_ACK    = 2'b11
    } state_t;

    localparam int CW = (DEB_CYC < 1) ? 1 : $clog2(DEB_CYC + 1);
    localparam int HW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

    localparam logic [W:0]    TH_VENT     = (W+1)'(T_VENT);
    localparam logic [W:0]    TH_ALARM    = (W+1)'(T_ALARM);
    localparam logic [W:0]    TH_VENT_LO  = (W+1)'(T_VENT - HYST);
    localparam logic [W:0]    TH_ALARM_LO = (W+1)'(T_ALARM - HYST);
    localparam logic [CW-1:0] CNT_MAX     = CW'(DEB_CYC);
    localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD);

    state_t        state_q, state_d;
    logic [1:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          vent_q, vent_d;
    logic          alarma_q, alarma_d;

    logic [W:0]    temp_ext;
    logic [1:0]    cur_lvl;
    logic [1:0]    lvl;
    logic          accepted;
    logic          expired;

    function automatic logic [1:0] state_level(input state_t s);
        case (s)
            S_NORMAL: state_level = 2'd0;
            S_VENT:   state_level = 2'd1;
            default:  state_level = 2'd2;
        endcase
    endfunction

    function automatic state_t level_state(input logic [1:0] l);
        case (l)
            2'd0:    level_state = S_NORMAL;
            2'd1:    level_state = S_VENT;
            default: level_state = S_ALARM;
        endcase
    endfunction

    always_comb begin
        temp_ext = {1'b0, Temperatura};
        cur_lvl  = state_level(state_q);
        lvl      = 2'd0;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        hold_d   = '0;
        state_d  = state_q;

        // Thresholds move with the current state so that falling levels see hysteresis.
        case (state_q)
            S_NORMAL: begin
                if (temp_ext >= TH_ALARM)     lvl = 2'd2;
                else if (temp_ext >= TH_VENT) lvl = 2'd1;
                else                          lvl = 2'd0;
            end
            S_VENT: begin
                if (temp_ext >= TH_ALARM)       lvl = 2'd2;
                else if (temp_ext < TH_VENT_LO) lvl = 2'd0;
                else                            lvl = 2'd1;
            end
            default: begin
                if (temp_ext < TH_VENT_LO)       lvl = 2'd0;
                else if (temp_ext < TH_ALARM_LO) lvl = 2'd1;
                else                             lvl = 2'd2;
            end
        endcase

        if (Muestra) begin
            if (lvl == cur_lvl) begin
                cnt_d = '0;
            end else if (lvl == cand_q) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            end else begin
                cand_d = lvl;
                cnt_d  = CW'(1);
            end
        end

`ifdef ALARMA_LATCH_EN
        if (state_q == S_ALARM) cnt_d = '0;
`endif

        // A saturated count in ALARM is a change waiting for the hold to expire.
        accepted = (cnt_d == CNT_MAX);

        if (state_q == S_ALARM)
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
        expired = (hold_d == HOLD_MAX);

        case (state_q)
            S_NORMAL, S_VENT: begin
                if (accepted) state_d = level_state(cand_d);
            end
            S_ALARM: begin
                if (Reconocer && expired)
                    state_d = S_ACK;
                else if (accepted && expired && cand_d != 2'd2)
                    state_d = level_state(cand_d);
            end
            default: begin
                if (accepted && cand_d != 2'd2) state_d = level_state(cand_d);
            end
        endcase

        if (state_d != state_q) begin
            cnt_d  = '0;
            cand_d = state_level(state_d);
        end

        vent_d   = (state_d == S_VENT) || (state_d == S_ACK);
        alarma_d = (state_d == S_ALARM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_NORMAL;
            cand_q   <= 2'd0;
            cnt_q    <= '0;
            hold_q   <= '0;
            vent_q   <= 1'b0;
            alarma_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            vent_q   <= vent_d;
            alarma_q <= alarma_d;
        end
    end

    assign Ventilacion = vent_q;
    assign Alarma      = alarma_q;
    assign Estado      = state_q;

endmodule

// File: tb/tb_control_ventilacion_alarma.sv
// Bench for control_ventilacion_alarma: directed scenarios plus random stimulus, all
// cycles compared against a behavioural model (also honours ALARMA_LATCH_EN).
module tb_control_ventilacion_alarma;

    localparam int W       = 5;
    localparam int T_VENT  = 20;
    localparam int T_ALARM = 26;
    localparam int HYST    = 2;
    localparam int DEB_CYC = 4;
    localparam int HOLD    = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] temp;
    logic         muestra;
    logic         reconocer;
    logic         ventilacion;
    logic         alarma;
    logic [1:0]   estado;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: state as 0 NORMAL, 1 VENT, 2 ALARM, 3 ACK.
    int m_st, m_cand, m_cnt, m_since;

    control_ventilacion_alarma #(
        .W(W), .T_VENT(T_VENT), .T_ALARM(T_ALARM),
        .HYST(HYST), .DEB_CYC(DEB_CYC), .HOLD(HOLD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Temperatura(temp),
        .Muestra(muestra),
        .Reconocer(reconocer),
        .Ventilacion(ventilacion),
        .Alarma(alarma),
        .Estado(estado)
    );

    always #5 clk = ~clk;

    function automatic int st_level(input int s);
        if (s == 0) return 0;
        if (s == 1) return 1;
        return 2;
    endfunction

    function automatic int sample_level(input int s, input int t);
        if (s == 0) return (t >= T_ALARM) ? 2 : (t >= T_VENT) ? 1 : 0;
        if (s == 1) return (t >= T_ALARM) ? 2 : (t < T_VENT - HYST) ? 0 : 1;
        return (t < T_VENT - HYST) ? 0 : (t < T_ALARM - HYST) ? 1 : 2;
    endfunction

    task automatic model_step(input int t, input bit m, input bit r, input bit rst);
        int l;
        int nst;
        bit expd;
        bit acc;
        if (rst) begin
            m_st = 0; m_cand = 0; m_cnt = 0; m_since = 0;
            return;
        end
        if (m) begin
            l = sample_level(m_st, t);
            if (l == st_level(m_st)) m_cnt = 0;
            else if (l == m_cand) m_cnt = (m_cnt + 1 > DEB_CYC) ? DEB_CYC : m_cnt + 1;
            else begin
                m_cand = l;
                m_cnt  = 1;
            end
        end
`ifdef ALARMA_LATCH_EN
        if (m_st == 2) m_cnt = 0;
`endif
        m_since = (m_st == 2) ? m_since + 1 : 0;
        expd = (m_since >= HOLD);
        acc  = (m_cnt == DEB_CYC);
        nst  = m_st;
        if (m_st == 0 || m_st == 1) begin
            if (acc) nst = m_cand;
        end else if (m_st == 2) begin
            if (r && expd) nst = 3;
            else if (acc && expd) nst = m_cand;
        end else begin
            if (acc) nst = m_cand;
        end
        if (nst != m_st) begin
            m_cnt  = 0;
            m_cand = st_level(nst);
            m_st   = nst;
        end
    endtask

    task automatic check_model();
        logic [1:0] exp_e;
        logic       exp_v;
        logic       exp_a;
        exp_e = 2'(m_st);
        exp_v = (m_st == 1) || (m_st == 3);
        exp_a = (m_st == 2);
        n_checks++;
        if (estado !== exp_e || ventilacion !== exp_v || alarma !== exp_a) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t: Estado=%b Vent=%b Alarma=%b, required Estado=%b Vent=%b Alarma=%b",
                     $time, estado, ventilacion, alarma, exp_e, exp_v, exp_a);
        end
    endtask

    // One clock cycle: drive, take the edge, advance the model, compare just after the edge.
    task automatic cyc(input int t, input bit m, input bit r, input bit rst);
        temp      = W'(t);
        muestra   = m;
        reconocer = r;
        reset     = rst;
        @(posedge clk);
        model_step(t, m, r, rst);
        #1;
        check_model();
    endtask

    task automatic samp(input int t, input int n);
        for (int i = 0; i < n; i++) cyc(t, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(int'($urandom_range(0, 31)), 1'b0, 1'b0, 1'b0);
    endtask

    // Literal expectation checked against both the DUT and the model.
    task automatic chk_lit(input string name, input logic [1:0] exp_e);
        logic exp_v;
        logic exp_a;
        exp_v = (exp_e == 2'b01) || (exp_e == 2'b11);
        exp_a = (exp_e == 2'b10);
        n_checks++;
        if (estado !== exp_e || ventilacion !== exp_v || alarma !== exp_a || m_st != int'(exp_e)) begin
            n_fail++;
            $display("FAIL %s: Estado=%b Vent=%b Alarma=%b model=%0d, required Estado=%b Vent=%b Alarma=%b",
                     name, estado, ventilacion, alarma, m_st, exp_e, exp_v, exp_a);
        end
    endtask

    initial begin
        temp = '0; muestra = 1'b0; reconocer = 1'b0; reset = 1'b1;
        m_st = 0; m_cand = 0; m_cnt = 0; m_since = 0;
        @(negedge clk);

        // Reset with arbitrary inputs
        for (int i = 0; i < 2; i++)
            cyc(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        chk_lit("reset", 2'b00);

        // Debounce: 3 samples then a cold one do not change state
        samp(22, 3);
        samp(15, 1);
        chk_lit("deb_3_broken", 2'b00);
        samp(22, 1); idle(1); samp(22, 1); idle(2); samp(22, 1); idle(1);
        chk_lit("deb_3_gaps", 2'b00);
        samp(22, 1);
        chk_lit("deb_4_vent", 2'b01);

        // Alarm entry, early acknowledge ignored, acknowledge after hold
        samp(27, 4);
        chk_lit("alarm_entry", 2'b10);
        idle(2);
        cyc(0, 1'b0, 1'b1, 1'b0);
        chk_lit("ack_early", 2'b10);
        idle(4);
        chk_lit("alarm_e7", 2'b10);
        cyc(0, 1'b0, 1'b1, 1'b0);
        chk_lit("ack_ok", 2'b11);

        // Hysteresis in ACK and VENT
        samp(24, 4);
        chk_lit("ack_hyst_hold", 2'b11);
        samp(23, 4);
        chk_lit("ack_to_vent", 2'b01);
        samp(19, 4);
        chk_lit("vent_hyst_hold", 2'b01);
        samp(17, 4);
        chk_lit("vent_to_normal", 2'b00);

        // Hold: change accepted early, exit exactly at expiry
        samp(27, 4);
        chk_lit("alarm_entry2", 2'b10);
        samp(10, 2); idle(1); samp(10, 2);
        idle(2);
        chk_lit("pending_e7", 2'b10);
        idle(1);
`ifdef ALARMA_LATCH_EN
        chk_lit("latch_e8", 2'b10);
        cyc(0, 1'b0, 1'b1, 1'b0);
        chk_lit("latch_ack", 2'b11);
        samp(10, 4);
        chk_lit("latch_normal", 2'b00);
`else
        chk_lit("expiry_exit", 2'b00);
`endif

        // Acknowledge wins over an accepted change on the same edge
        samp(27, 4);
        chk_lit("alarm_entry3", 2'b10);
        idle(7);
        samp(10, 3);
        cyc(10, 1'b1, 1'b1, 1'b0);
        chk_lit("simul_ack", 2'b11);
        samp(10, 4);
        chk_lit("ack_to_normal", 2'b00);

        // Reset discards a 3-of-4 run
        samp(22, 3);
        cyc(22, 1'b0, 1'b0, 1'b1);
        chk_lit("mid_reset", 2'b00);
        samp(22, 3);
        chk_lit("after_reset", 2'b00);

        // Random phase, temperatures weighted toward the thresholds
        for (int i = 0; i < 4000; i++) begin
            int t;
            bit m, r, rs;
            t  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(15, 28));
            m  = ($urandom_range(0, 99) < 60);
            r  = ($urandom_range(0, 99) < 8);
            rs = ($urandom_range(0, 999) < 5);
            cyc(t, m, r, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
